mc_ctrl: RTL and testbench

Multi-cycle control FSM that sequences the PC register, instruction register, GRF, ALU and DM of the MIPS-lite datapath.
- Each instruction runs over 2-5 cycles.
- The block drives the PC write enable and next-PC select, so the PC advances only at defined points.
- It sits between the IR opcode/funct fields, the ALU zero flag and every datapath write enable and mux select.

---
 rtl/mc_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mc_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS-lite datapath: sequences PC, IR, GRF, ALU and DM
// enables/selects over 2-5 cycles per instruction.
module mc_ctrl #(
  parameter logic [1:0] PC_PLUS4_SEL = 2'd0,
  parameter logic [1:0] BRANCH_SEL   = 2'd1,
  parameter logic [1:0] JUMP_SEL     = 2'd2,
  parameter logic [1:0] REG_SEL      = 2'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_we,
  output logic [1:0] npc_sel,
  output logic       ir_we,
  output logic       reg_we,
  output logic       mem_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       alu_b_sel,
  output logic       ext_op,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXE    = 4'd2,
    S_ALUWB  = 4'd3,
    S_MADDR  = 4'd4,
    S_MREAD  = 4'd5,
    S_MWB    = 4'd6,
    S_MWRITE = 4'd7,
    S_BRANCH = 4'd8
  } state_t;

  state_t state_q, state_d;

  logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;

  always_comb begin
    is_r    = (opcode == 6'b000000);
    is_addu = is_r && (funct == 6'b100001);
    is_subu = is_r && (funct == 6'b100011);
    is_jr   = is_r && (funct == 6'b001000);
    is_ori  = (opcode == 6'b001101);
    is_lui  = (opcode == 6'b001111);
    is_lw   = (opcode == 6'b100011);
    is_sw   = (opcode == 6'b101011);
    is_beq  = (opcode == 6'b000100);
    is_j    = (opcode == 6'b000010);
    is_jal  = (opcode == 6'b000011);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_we      = 1'b0;
    npc_sel    = PC_PLUS4_SEL;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    mem_we     = 1'b0;
    reg_dst    = 2'd0;
    wd_sel     = 2'd0;
    alu_b_sel  = 1'b0;
    ext_op     = 1'b0;
    alu_op     = 2'd0;
    instr_done = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        npc_sel = PC_PLUS4_SEL;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_FETCH;
        if (is_j || is_jal) begin
          pc_we      = 1'b1;
          npc_sel    = JUMP_SEL;
          instr_done = 1'b1;
          if (is_jal) begin
            reg_we  = 1'b1;
            reg_dst = 2'd2;
            wd_sel  = 2'd2;
          end
        end else if (is_jr) begin
          pc_we      = 1'b1;
          npc_sel    = REG_SEL;
          instr_done = 1'b1;
        end else if (is_beq) begin
          state_d = S_BRANCH;
        end else if (is_addu || is_subu || is_ori || is_lui) begin
          state_d = S_EXE;
        end else if (is_lw || is_sw) begin
          state_d = S_MADDR;
        end else begin
          instr_done = 1'b1;
        end
      end
      S_EXE, S_ALUWB: begin
        // ALU controls are held through writeback so the result stays valid on the GRF port
        if (is_subu) begin
          alu_op = 2'd1;
        end else if (is_ori) begin
          alu_op    = 2'd2;
          alu_b_sel = 1'b1;
        end else if (is_lui) begin
          alu_op    = 2'd3;
          alu_b_sel = 1'b1;
        end
        if (state_q == S_EXE) begin
          state_d = S_ALUWB;
        end else begin
          reg_we     = 1'b1;
          wd_sel     = 2'd0;
          reg_dst    = is_r ? 2'd1 : 2'd0;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_MADDR: begin
        alu_b_sel = 1'b1;
        ext_op    = 1'b1;
        state_d   = is_sw ? S_MWRITE : S_MREAD;
      end
      S_MREAD: begin
        alu_b_sel = 1'b1;
        ext_op    = 1'b1;
        state_d   = S_MWB;
      end
      S_MWB: begin
        reg_we     = 1'b1;
        reg_dst    = 2'd0;
        wd_sel     = 2'd1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MWRITE: begin
        alu_b_sel  = 1'b1;
        ext_op     = 1'b1;
        mem_we     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_op     = 2'd1;
        pc_we      = zero;
        npc_sel    = BRANCH_SEL;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // A cycle under reset commits nothing, whatever state the FSM was in
    if (reset) begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      reg_we     = 1'b0;
      mem_we     = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: a per-instruction reference model queues the expected
// cycle-by-cycle control vectors; a negedge monitor pops and compares them.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       pc_we, ir_we, reg_we, mem_we, alu_b_sel, ext_op, instr_done;
  logic [1:0] npc_sel, reg_dst, wd_sel, alu_op;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_we(pc_we), .npc_sel(npc_sel), .ir_we(ir_we), .reg_we(reg_we), .mem_we(mem_we),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_b_sel(alu_b_sel), .ext_op(ext_op),
    .alu_op(alu_op), .instr_done(instr_done), .state(state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pc_we;
    logic [1:0] npc;
    logic       ir_we;
    logic       reg_we;
    logic       mem_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_b;
    logic       ext;
    logic [1:0] alu_op;
    logic       done;
  } rec_t;

  typedef enum int {K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_NOP} kind_t;

  rec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t blank(input logic [3:0] st);
    rec_t r;
    r = '0;
    r.st = st;
    return r;
  endfunction

  // Expected control vectors for one instruction, written instruction by instruction
  task automatic model_push(input kind_t k, input logic z);
    rec_t r;
    r = blank(4'd0); r.pc_we = 1; r.npc = 2'd0; r.ir_we = 1;
    sb.push_back(r);
    r = blank(4'd1);
    case (k)
      K_J:   begin r.pc_we = 1; r.npc = 2'd2; r.done = 1; sb.push_back(r); end
      K_JAL: begin
        r.pc_we = 1; r.npc = 2'd2; r.done = 1; r.reg_we = 1; r.reg_dst = 2'd2; r.wd_sel = 2'd2;
        sb.push_back(r);
      end
      K_JR:  begin r.pc_we = 1; r.npc = 2'd3; r.done = 1; sb.push_back(r); end
      K_NOP: begin r.done = 1; sb.push_back(r); end
      K_BEQ: begin
        sb.push_back(r);
        r = blank(4'd8); r.alu_op = 2'd1; r.pc_we = z; r.npc = 2'd1; r.done = 1;
        sb.push_back(r);
      end
      K_ADDU, K_SUBU, K_ORI, K_LUI: begin
        sb.push_back(r);
        r = blank(4'd2);
        case (k)
          K_SUBU: r.alu_op = 2'd1;
          K_ORI:  begin r.alu_op = 2'd2; r.alu_b = 1; end
          K_LUI:  begin r.alu_op = 2'd3; r.alu_b = 1; end
          default: r.alu_op = 2'd0;
        endcase
        sb.push_back(r);
        r.st = 4'd3; r.reg_we = 1; r.wd_sel = 2'd0; r.done = 1;
        r.reg_dst = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
        sb.push_back(r);
      end
      K_LW, K_SW: begin
        sb.push_back(r);
        r = blank(4'd4); r.alu_b = 1; r.ext = 1;
        sb.push_back(r);
        if (k == K_LW) begin
          r.st = 4'd5;
          sb.push_back(r);
          r = blank(4'd6); r.reg_we = 1; r.wd_sel = 2'd1; r.done = 1;
          sb.push_back(r);
        end else begin
          r.st = 4'd7; r.mem_we = 1; r.done = 1;
          sb.push_back(r);
        end
      end
      default: ;
    endcase
  endtask

  function automatic int latency(input kind_t k);
    case (k)
      K_J, K_JAL, K_JR, K_NOP: return 2;
      K_BEQ: return 3;
      K_LW:  return 5;
      default: return 4;
    endcase
  endfunction

  task automatic encode(input kind_t k);
    funct = 6'($urandom_range(0, 63));
    case (k)
      K_ADDU: begin opcode = 6'b000000; funct = 6'b100001; end
      K_SUBU: begin opcode = 6'b000000; funct = 6'b100011; end
      K_JR:   begin opcode = 6'b000000; funct = 6'b001000; end
      K_ORI:  opcode = 6'b001101;
      K_LUI:  opcode = 6'b001111;
      K_LW:   opcode = 6'b100011;
      K_SW:   opcode = 6'b101011;
      K_BEQ:  opcode = 6'b000100;
      K_J:    opcode = 6'b000010;
      K_JAL:  opcode = 6'b000011;
      default: begin
        case ($urandom_range(0, 2))
          0: opcode = 6'b111111;
          1: begin opcode = 6'b000000; funct = 6'b000000; end
          default: begin opcode = 6'b000000; funct = 6'b100000; end
        endcase
      end
    endcase
  endtask

  // Called just after a posedge with the FSM sitting in FETCH
  task automatic run_instr(input kind_t k, input logic z);
    encode(k);
    zero = z;
    model_push(k, z);
    repeat (latency(k)) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    rec_t act, exp;
    if (reset === 1'b0) begin
      act = '{state, pc_we, npc_sel, ir_we, reg_we, mem_we, reg_dst, wd_sel, alu_b_sel,
              ext_op, alu_op, instr_done};
      if (sb.size() == 0) begin
        chk("unexpected_cycle", 32'(act), 32'h7ffff);
      end else begin
        exp = sb.pop_front();
        chk("ctrl_vector", 32'(act), 32'(exp));
      end
    end
  end

  initial begin
    reset = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
    @(negedge clk);
    chk("reset_writes_0", {27'd0, pc_we, ir_we, reg_we, mem_we, instr_done}, 32'd0);
    @(negedge clk);
    chk("reset_writes_1", {27'd0, pc_we, ir_we, reg_we, mem_we, instr_done}, 32'd0);
    chk("reset_state", 32'(state), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(K_ADDU, 1'b0);
    run_instr(K_LW, 1'b0);
    run_instr(K_SW, 1'b1);
    run_instr(K_BEQ, 1'b1);
    run_instr(K_BEQ, 1'b0);
    run_instr(K_JAL, 1'b0);
    run_instr(K_JR, 1'b1);
    run_instr(K_NOP, 1'b0);
    run_instr(K_SUBU, 1'b1);
    run_instr(K_ORI, 1'b0);
    run_instr(K_LUI, 1'b1);
    run_instr(K_J, 1'b0);

    // Reset arriving in MWRITE must suppress the store and return to FETCH
    encode(K_SW);
    zero = 1'b0;
    model_push(K_SW, 1'b0);
    void'(sb.pop_back());
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("midreset_state", 32'(state), 32'd7);
    chk("midreset_mem_we", 32'(mem_we), 32'd0);
    chk("midreset_done_pc", {30'd0, instr_done, pc_we}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr(K_NOP, 1'b1);

    for (int i = 0; i < 80; i++) begin
      run_instr(kind_t'($urandom_range(0, 10)), 1'($urandom_range(0, 1)));
    end

    reset = 1'b1;
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
